div_iter: RTL and testbench

Iterative radix-2 restoring divider for the M-extension execute stage; it sits beside the Booth/Wallace multiplier and shares the same request/result handshake into the EX pipeline. It covers DIV/DIVU/REM/REMU in 64-bit mode and DIVW/DIVUW/REMW/REMUW in word mode. Each request produces both quotient and remainder. Divide-by-zero and signed overflow are resolved in one cycle without iterating.

---
 rtl/div_iter.sv | 237 +++++++++++++++++++++++
 tb/tb_div_iter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the M-extension execute stage.
// Serves DIV/DIVU/REM/REMU (64-bit) and DIVW/DIVUW/REMW/REMUW (word mode).
// Every request yields both a quotient and a remainder. Divide-by-zero and
// signed overflow skip the iteration loop entirely.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   div_valid/div_ready   request handshake (div_ready high only in IDLE)
//   div_signed, div_word  operation type (signed / 32-bit word)
//   dividend, divisor     64-bit operands
//   flush                 pipeline kill; returns to IDLE and drops any result
//   out_valid/out_ready   result handshake (result held until taken)
//   quotient, remainder   registered 64-bit results
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [63:0] f_sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] f_neg(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_div_ready;
    logic        r_out_valid;
    logic        w_div_ready_nxt;
    logic        w_out_valid_nxt;

    logic [63:0] r_rem;        // partial remainder
    logic [63:0] r_quo;        // dividend shift register, fills with quotient bits
    logic [63:0] r_dsr;        // divisor magnitude
    logic [6:0]  r_cnt;        // iterations still to run
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_word;
    logic [63:0] r_quotient;
    logic [63:0] r_remainder;

    // Operand conditioning, evaluated on the request inputs.
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_mag;
    logic [63:0] w_b_mag;
    logic [63:0] w_min_neg;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_accept;

    assign w_a_ext    = div_word ? (div_signed ? f_sext32(dividend[31:0]) : {32'd0, dividend[31:0]})
                                 : dividend;
    assign w_b_ext    = div_word ? (div_signed ? f_sext32(divisor[31:0]) : {32'd0, divisor[31:0]})
                                 : divisor;
    assign w_a_neg    = div_signed & w_a_ext[63];
    assign w_b_neg    = div_signed & w_b_ext[63];
    assign w_a_mag    = w_a_neg ? f_neg(w_a_ext) : w_a_ext;
    assign w_b_mag    = w_b_neg ? f_neg(w_b_ext) : w_b_ext;
    assign w_min_neg  = div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_div_zero = (w_b_ext == 64'd0);
    assign w_ovf      = div_signed & (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF) & (w_a_ext == w_min_neg);
    assign w_accept   = (r_state == ST_IDLE) & div_valid & ~flush;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The shifted value is 65 bits; the difference fits in 64 whenever it is kept.
    logic [64:0] w_shift;
    logic        w_fits;
    logic [63:0] w_diff;

    assign w_shift = {r_rem, r_quo[63]};
    assign w_fits  = (w_shift >= {1'b0, r_dsr});
    assign w_diff  = w_shift[63:0] - r_dsr;

    // Sign correction and word-mode extension applied in FIX.
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_q_fin;
    logic [63:0] w_r_fin;

    assign w_q_fix = r_neg_q ? f_neg(r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? f_neg(r_rem) : r_rem;
    assign w_q_fin = r_word ? f_sext32(w_q_fix[31:0]) : w_q_fix;
    assign w_r_fin = r_word ? f_sext32(w_r_fix[31:0]) : w_r_fix;

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div_ready <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_ready <= w_div_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition.
    // CALC leaves on the registered zero count, so it lasts N+1 cycles and
    // the count compare stays off the subtract path.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (w_div_zero | w_ovf) ? ST_FIX : ST_CALC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == 7'd0) begin
                        w_state_nxt = ST_FIX;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end
                ST_FIX:  w_state_nxt = ST_DONE;
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Handshake output decode from the next state, registered above.
    always_comb begin
        w_div_ready_nxt = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_div_ready_nxt = 1'b1;
            ST_DONE: w_out_valid_nxt = 1'b1;
            default: begin
                w_div_ready_nxt = 1'b0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath: operand load, iteration, and result capture.
    // Special cases preload their final answers and pass through FIX with
    // sign correction disabled, so word-mode extension is shared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= 64'd0;
            r_quo       <= 64'd0;
            r_dsr       <= 64'd0;
            r_cnt       <= 7'd0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_word      <= 1'b0;
            r_quotient  <= 64'd0;
            r_remainder <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word <= div_word;
                        r_dsr  <= w_b_mag;
                        if (w_div_zero) begin
                            r_quo   <= 64'hFFFF_FFFF_FFFF_FFFF;
                            r_rem   <= w_a_ext;
                            r_cnt   <= 7'd0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_ovf) begin
                            r_quo   <= w_a_ext;
                            r_rem   <= 64'd0;
                            r_cnt   <= 7'd0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            // Word magnitudes sit in the top half so 32 shifts finish.
                            r_quo   <= div_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                            r_rem   <= 64'd0;
                            r_cnt   <= div_word ? 7'd32 : 7'd64;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush && (r_cnt != 7'd0)) begin
                        r_rem <= w_fits ? w_diff : w_shift[63:0];
                        r_quo <= {r_quo[62:0], w_fits};
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        r_quotient  <= w_q_fin;
                        r_remainder <= w_r_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_ready = r_div_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter: reset state, 64-bit and word divides,
// special cases, flush/reset abort, backpressure and back-to-back requests.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        div_word;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int total = 0;
    int bad   = 0;

    div_iter dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, then count edges after the accept edge until out_valid.
    task automatic run_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] q, output logic [63:0] r, output int lat);
        @(negedge clk);
        div_signed = s;
        div_word   = w;
        dividend   = a;
        divisor    = b;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = i;
        end
        if (lat == 0) lat = 999;
        q = quotient;
        r = remainder;
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", div_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (quotient !== 64'd0) begin bad++; $display("FAIL reset_q got=%h want=0", quotient); end
        total++; if (remainder !== 64'd0) begin bad++; $display("FAIL reset_r got=%h want=0", remainder); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned64();
        logic [63:0] q, r;
        int lat;
        run_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat);
        total++; if (q !== 64'd14) begin bad++; $display("FAIL divu_q got=%h want=%h", q, 64'd14); end
        total++; if (r !== 64'd2) begin bad++; $display("FAIL divu_r got=%h want=%h", r, 64'd2); end
        total++; if (lat !== 66) begin bad++; $display("FAIL divu_latency got=%0d want=66", lat); end
        take_result();
    endtask

    task automatic test_signed64();
        logic [63:0] q, r;
        int lat;
        run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, q, r, lat);
        total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_q got=%h want=fffffffffffffffd", q); end
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div_r got=%h want=ffffffffffffffff", r); end
        total++; if (lat !== 66) begin bad++; $display("FAIL div_latency got=%0d want=66", lat); end
        take_result();
        run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, q, r, lat);
        total++; if (q !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf64_q got=%h want=8000000000000000", q); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL ovf64_r got=%h want=0", r); end
        total++; if (lat !== 1) begin bad++; $display("FAIL ovf64_latency got=%0d want=1", lat); end
        take_result();
    endtask

    task automatic test_div_zero();
        logic [63:0] q, r;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 1'b0, 64'h1234, 64'd0, q, r, lat);
            total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL dz_q s=%0d got=%h want=ffffffffffffffff", s, q); end
            total++; if (r !== 64'h1234) begin bad++; $display("FAIL dz_r s=%0d got=%h want=1234", s, r); end
            total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency s=%0d got=%0d want=1", s, lat); end
            take_result();
        end
    endtask

    task automatic test_word();
        logic [63:0] q, r;
        int lat;
        run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, q, r, lat);
        total++; if (q !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL divw_ovf_q got=%h want=ffffffff80000000", q); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL divw_ovf_r got=%h want=0", r); end
        total++; if (lat !== 1) begin bad++; $display("FAIL divw_ovf_latency got=%0d want=1", lat); end
        take_result();
        run_op(1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, q, r, lat);
        total++; if (q !== 64'h0000_0000_7FFF_FFFF) begin bad++; $display("FAIL divuw_q got=%h want=000000007fffffff", q); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL divuw_r got=%h want=0", r); end
        total++; if (lat !== 34) begin bad++; $display("FAIL divuw_latency got=%0d want=34", lat); end
        take_result();
        // Upper operand bits must be ignored in word mode.
        run_op(1'b1, 1'b1, 64'hDEAD_BEEF_FFFF_FF9C, 64'h1234_5678_0000_0007, q, r, lat);
        total++; if (q !== 64'hFFFF_FFFF_FFFF_FFF2) begin bad++; $display("FAIL divw_q got=%h want=fffffffffffffff2", q); end
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL remw_r got=%h want=fffffffffffffffe", r); end
        take_result();
        // Unsigned word result with bit 31 set is still sign-extended.
        run_op(1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, q, r, lat);
        total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL divuw_sext_q got=%h want=ffffffffffffffff", q); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL divuw_sext_r got=%h want=0", r); end
        take_result();
    endtask

    task automatic test_flush();
        logic [63:0] q, r;
        int lat;
        @(negedge clk);
        div_signed = 1'b0; div_word = 1'b0; dividend = 64'd12345; divisor = 64'd3; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        div_valid = 1'b1; dividend = 64'd5; divisor = 64'd0;
        @(posedge clk);
        #1;
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL flush_calc_ready got=%b want=1", div_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_calc_valid got=%b want=0", out_valid); end
        // Still flushing while idle with a request pending: must not accept.
        @(posedge clk);
        #1;
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_accept ready got=%b want=1", div_ready); end
        flush = 1'b0;
        div_valid = 1'b0;
        run_op(1'b0, 1'b0, 64'd1000, 64'd10, q, r, lat);
        total++; if (q !== 64'd100) begin bad++; $display("FAIL flush_next_q got=%h want=%h", q, 64'd100); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL flush_next_r got=%h want=0", r); end
        total++; if (lat !== 66) begin bad++; $display("FAIL flush_next_latency got=%0d want=66", lat); end
        // Flush while a result is waiting discards it.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b want=0", out_valid); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL flush_done_ready got=%b want=1", div_ready); end
    endtask

    task automatic test_reset_abort();
        logic [63:0] q, r;
        int lat;
        @(negedge clk);
        div_signed = 1'b1; div_word = 1'b0; dividend = 64'd999999; divisor = 64'd7; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL rst_abort_ready got=%b want=1", div_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_abort_valid got=%b want=0", out_valid); end
        #1;
        rst = 1'b0;
        run_op(1'b0, 1'b0, 64'd1000, 64'd10, q, r, lat);
        total++; if (q !== 64'd100) begin bad++; $display("FAIL rst_next_q got=%h want=%h", q, 64'd100); end
        total++; if (r !== 64'd0) begin bad++; $display("FAIL rst_next_r got=%h want=0", r); end
        total++; if (lat !== 66) begin bad++; $display("FAIL rst_next_latency got=%0d want=66", lat); end
        take_result();
    endtask

    task automatic test_backpressure();
        logic [63:0] q, r;
        int lat;
        run_op(1'b0, 1'b0, 64'd50, 64'd5, q, r, lat);
        total++; if (q !== 64'd10) begin bad++; $display("FAIL bp_q got=%h want=%h", q, 64'd10); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || div_ready !== 1'b0 || quotient !== 64'd10 || remainder !== 64'd0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=a r=0",
                         i, out_valid, div_ready, quotient, remainder);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_before got=%b want=0", div_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b want=0", out_valid); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", div_ready); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        @(negedge clk);
        out_ready  = 1'b1;
        div_signed = 1'b1; div_word = 1'b1; dividend = 64'd100; divisor = 64'hFFFF_FFFF_FFFF_FFF9;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        // Next request waits on the bus; div_ready is low until the result is taken.
        div_signed = 1'b0; div_word = 1'b1; dividend = 64'h0000_0001_0000_000A; divisor = 64'd3;
        cnt = 0;
        for (int i = 1; i <= 200 && cnt == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt = i;
        end
        total++; if (cnt !== 34) begin bad++; $display("FAIL b2b_a_latency got=%0d want=34", cnt); end
        total++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFF2) begin bad++; $display("FAIL b2b_a_q got=%h want=fffffffffffffff2", quotient); end
        total++; if (remainder !== 64'd2) begin bad++; $display("FAIL b2b_a_r got=%h want=2", remainder); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_handshake got v=%b rdy=%b want v=0 rdy=1", out_valid, div_ready);
        end
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        cnt = 0;
        for (int i = 2; i <= 200 && cnt == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt = i;
        end
        total++; if (cnt !== 35) begin bad++; $display("FAIL b2b_b_latency got=%0d want=35", cnt); end
        total++; if (quotient !== 64'd3) begin bad++; $display("FAIL b2b_b_q got=%h want=3", quotient); end
        total++; if (remainder !== 64'd1) begin bad++; $display("FAIL b2b_b_r got=%h want=1", remainder); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_word   = 1'b0;
        dividend   = 64'd0;
        divisor    = 64'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_unsigned64();
        test_signed64();
        test_div_zero();
        test_word();
        test_flush();
        test_reset_abort();
        test_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
